// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph code type, named glyph codes and sequencer state shared by the
// code sequencer and the glyph decoder.
package seg7_pkg;
    localparam int GLYPH_CODE_W = 6;
    typedef logic [GLYPH_CODE_W-1:0] code_t;
    localparam code_t CODE_HEX_LAST   = 6'd15;
    localparam code_t CODE_GLYPH_LAST = 6'd41;
    localparam code_t CODE_A          = 6'd16;
    localparam code_t CODE_P          = 6'd33;
    localparam code_t CODE_DEG        = 6'd41;
    typedef enum logic {PAUSE, RUN} seq_state_t;
endpackage

// File: rtl/seg7_code_sequencer_button_sync_edge.sv
// button_sync_edge: two-flop synchroniser for a raw push-button plus a
// one-cycle pulse on its synchronised rising edge.
module button_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh <= '0;
        else        sh <= {sh[1:0], btn};
    assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/seg7_code_sequencer.sv
// seg7_code_sequencer: steps the glyph code through [CODE_LO, CODE_HI], either
// automatically at a divided rate or one code per button press.
module seg7_code_sequencer
    import seg7_pkg::*;
#(
    parameter int CODE_W  = GLYPH_CODE_W,
    parameter int CODE_LO = 0,
    parameter int CODE_HI = 41,
    parameter int DIV     = 2
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic              load_i,
    input  logic [CODE_W-1:0] load_code_i,
    output logic [CODE_W-1:0] code_o,
    output logic              adv_o,
    output logic              wrap_o
);
    localparam int CNT_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CODE_W-1:0] LO   = CODE_W'(CODE_LO);
    localparam logic [CODE_W-1:0] HI   = CODE_W'(CODE_HI);
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(DIV - 1);

    seq_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CODE_W-1:0] code_n;
    logic step_pulse, tick, adv_req, in_rng, adv_n, wrap_n;

    button_sync_edge u_step (
        .clk   (clk_2),
        .rst_n (rst_n),
        .btn   (step_i),
        .pulse (step_pulse)
    );

    always_comb begin
        state_n = run_i ? RUN : PAUSE;
        tick    = state == RUN && cnt == LAST;
        adv_req = state == RUN ? tick : step_pulse;
        // offset compare keeps the range check free of constant-zero bounds
        in_rng  = CODE_W'(load_code_i - LO) <= CODE_W'(HI - LO);
        cnt_n   = (load_i || state != state_n || state == PAUSE || tick) ? '0 : cnt + CNT_W'(1);
        adv_n   = adv_req && !load_i;
        wrap_n  = adv_n && (dir_i ? code_o == LO : code_o == HI);
        code_n  = load_i   ? (in_rng ? load_code_i : LO)
                : !adv_req ? code_o
                : dir_i    ? (code_o == LO ? HI : code_o - CODE_W'(1))
                :            (code_o == HI ? LO : code_o + CODE_W'(1));
    end

    always_ff @(posedge clk_2 or negedge rst_n)
        if (!rst_n) begin
            state  <= PAUSE;
            cnt    <= '0;
            code_o <= LO;
            adv_o  <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            code_o <= code_n;
            adv_o  <= adv_n;
            wrap_o <= wrap_n;
        end
endmodule

// File: tb/tb_seg7_code_sequencer.sv
// tb_seg7_code_sequencer: directed and random stimulus on a default instance and a
// DIV=1, CODE_LO=CODE_HI=7 instance, both checked against a cycle model.
module tb_seg7_code_sequencer;
    logic clk_2 = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n, run, step, dir, load;
    logic [5:0] lc;
    logic [5:0] code_a, code_b;
    logic adv_a, wrap_a, adv_b, wrap_b;
    int checks = 0;
    int errors = 0;

    always begin
        #5;
        if (clk_en) clk_2 = ~clk_2;
    end

    seg7_code_sequencer dut_a (
        .clk_2(clk_2), .rst_n(rst_n), .run_i(run), .step_i(step), .dir_i(dir),
        .load_i(load), .load_code_i(lc), .code_o(code_a), .adv_o(adv_a), .wrap_o(wrap_a)
    );

    seg7_code_sequencer #(.CODE_W(6), .CODE_LO(7), .CODE_HI(7), .DIV(1)) dut_b (
        .clk_2(clk_2), .rst_n(rst_n), .run_i(run), .step_i(step), .dir_i(dir),
        .load_i(load), .load_code_i(lc), .code_o(code_b), .adv_o(adv_b), .wrap_o(wrap_b)
    );

    // model: index 0 mirrors dut_a's parameters, index 1 dut_b's
    int dv[2]  = '{2, 1};
    int lov[2] = '{0, 7};
    int hiv[2] = '{41, 7};
    int m_code[2], m_cnt[2], m_adv[2], m_wrap[2];
    bit m_run[2];
    bit hs[2][3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_code[i] = lov[i];
            m_cnt[i] = 0;
            m_run[i] = 0;
            m_adv[i] = 0;
            m_wrap[i] = 0;
            hs[i] = '{0, 0, 0};
        end
    endtask

    task automatic model_step();
        int n, off, lv;
        bit pulse, req;
        for (int i = 0; i < 2; i++) begin
            n = hiv[i] - lov[i] + 1;
            off = m_code[i] - lov[i];
            pulse = hs[i][1] && !hs[i][2];
            req = m_run[i] ? (m_cnt[i] == dv[i] - 1) : pulse;
            m_adv[i] = 0;
            m_wrap[i] = 0;
            lv = int'(lc);
            if (load) m_code[i] = (lv >= lov[i] && lv <= hiv[i]) ? lv : lov[i];
            else if (req) begin
                m_adv[i] = 1;
                m_wrap[i] = dir ? int'(off == 0) : int'(off == n - 1);
                m_code[i] = lov[i] + (dir ? (off + n - 1) % n : (off + 1) % n);
            end
            m_cnt[i] = (load || run != m_run[i] || !run) ? 0 : (m_cnt[i] + 1) % dv[i];
            m_run[i] = run;
            hs[i][2] = hs[i][1];
            hs[i][1] = hs[i][0];
            hs[i][0] = step;
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        model_step();
        #1;
        chk("a_code", code_a, m_code[0]);
        chk("a_adv", adv_a, m_adv[0]);
        chk("a_wrap", wrap_a, m_wrap[0]);
        chk("b_code", code_b, m_code[1]);
        chk("b_adv", adv_b, m_adv[1]);
        chk("b_wrap", wrap_b, m_wrap[1]);
    endtask

    initial begin
        int wraps, advs, guard;
        rst_n = 0; run = 0; step = 0; dir = 0; load = 0; lc = '0;
        model_reset();
        @(posedge clk_2); #1;
        chk("rst_code", code_a, 0);
        chk("rst_adv", adv_a, 0);
        chk("rst_wrap", wrap_a, 0);
        chk("rst_code_b", code_b, 7);
        @(negedge clk_2);
        rst_n = 1;

        // auto-run upward through the full range and one wrap
        run = 1;
        wraps = 0;
        repeat (90) begin
            tick();
            wraps += int'(wrap_a);
        end
        chk("t1_wraps", wraps, 1);

        // downward from 0 wraps to 41, then 40
        load = 1; lc = 6'd0;
        tick();
        load = 0; dir = 1;
        tick(); tick();
        chk("t2_code41", code_a, 41);
        chk("t2_wrap41", wrap_a, 1);
        tick(); tick();
        chk("t2_code40", code_a, 40);
        chk("t2_wrap40", wrap_a, 0);

        // paused stepping: a held button gives one step on the third edge
        run = 0; dir = 0;
        tick(); tick();
        load = 1; lc = 6'd3;
        tick();
        load = 0;
        tick();
        step = 1;
        advs = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            advs += int'(adv_a);
            if (k == 3) begin
                chk("t3_adv3", adv_a, 1);
                chk("t3_code4", code_a, 4);
            end
        end
        step = 0;
        repeat (3) begin
            tick();
            advs += int'(adv_a);
        end
        chk("t3_advs", advs, 1);
        run = 1;
        for (int k = 0; k < 24; k++) begin
            if (k % 3 == 0) step = ~step;
            tick();
        end
        step = 0;

        // load clamp and load on a tick edge
        load = 1; lc = 6'd50;
        tick();
        load = 0;
        chk("t4_clamp", code_a, 0);
        chk("t4_clamp_b", code_b, 7);
        guard = 0;
        while (!(m_run[0] && m_cnt[0] == 1) && guard < 8) begin
            tick();
            guard++;
        end
        chk("t4_guard", int'(guard < 8), 1);
        load = 1; lc = 6'd16;
        tick();
        load = 0;
        chk("t4_load16", code_a, 16);
        chk("t4_load_adv", adv_a, 0);
        tick();
        chk("t4_no_adv", adv_a, 0);
        tick();
        chk("t4_adv", adv_a, 1);
        chk("t4_code17", code_a, 17);

        // asynchronous reset with the clock stopped
        repeat (3) tick();
        @(negedge clk_2);
        #1 clk_en = 0;
        #10 rst_n = 0;
        #1;
        chk("t5_code", code_a, 0);
        chk("t5_adv", adv_a, 0);
        chk("t5_wrap", wrap_a, 0);
        model_reset();
        #5 rst_n = 1;
        #5 clk_en = 1;
        tick();
        chk("t5_e1_code", code_a, 0);
        tick();
        chk("t5_e2_adv", adv_a, 0);
        tick();
        chk("t5_e3_adv", adv_a, 1);
        chk("t5_e3_code", code_a, 1);

        // single-code range at DIV=1 holds with adv and wrap every cycle
        repeat (5) begin
            tick();
            chk("t6_code", code_b, 7);
            chk("t6_adv", adv_b, 1);
            chk("t6_wrap", wrap_b, 1);
        end

        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 3) == 0) step = ~step;
            load = $urandom_range(0, 15) == 0;
            lc = 6'($urandom_range(0, 63));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
